// File: rtl/rates_msg_scheduler.sv
// rates_msg_scheduler: message-granular round-robin egress arbiter with a
// per-port signed byte-credit token bucket. A port may start a message only
// when its bucket covers one full beat; once granted, the message runs to its
// last beat regardless of credit, enable or rate changes.
module rates_msg_scheduler #(
  parameter int NUM_PORTS           = 4,
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int RATE_W              = 8,
  parameter int BKT_W               = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_PORTS-1:0]                     cfg_enable,
  input  logic [NUM_PORTS*RATE_W-1:0]              cfg_rate,
  input  logic [NUM_PORTS-1:0]                     in_valid,
  input  logic [NUM_PORTS-1:0]                     in_last,
  input  logic [NUM_PORTS*DATA_WIDTH_IN_BYTES*8-1:0] in_data,
  output logic [NUM_PORTS-1:0]                     in_ready,
  output logic                                     out_valid,
  output logic                                     out_last,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0]         out_data,
  input  logic                                     out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]             out_port,
  output logic                                     busy,
  output logic [31:0]                              msg_cnt
);

  localparam int DWB   = DATA_WIDTH_IN_BYTES * 8;
  localparam int PW    = $clog2(NUM_PORTS);
  // Two guard bits: bucket + rate - cost cannot overflow before saturation.
  localparam int SUM_W = BKT_W + 2;

  localparam logic signed [BKT_W-1:0] BUCKET_MAX = {1'b0, {(BKT_W-1){1'b1}}};
  localparam logic signed [BKT_W-1:0] BUCKET_MIN = {1'b1, {(BKT_W-1){1'b0}}};
  localparam logic signed [BKT_W-1:0] BEAT_COST  = BKT_W'(DATA_WIDTH_IN_BYTES);
  localparam logic signed [SUM_W-1:0] SUM_MAX    = {2'b00, BUCKET_MAX};
  localparam logic signed [SUM_W-1:0] SUM_MIN    = {2'b11, BUCKET_MIN};
  localparam logic signed [SUM_W-1:0] COST_EXT   = SUM_W'(DATA_WIDTH_IN_BYTES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           grant_q, grant_d;
  logic [PW-1:0]           rr_q, rr_d;
  logic [31:0]             msg_cnt_q, msg_cnt_d;
  logic signed [BKT_W-1:0] bucket_q [NUM_PORTS];
  logic signed [BKT_W-1:0] bucket_d [NUM_PORTS];

  logic [DWB-1:0]          data_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0]    eligible;
  logic [NUM_PORTS-1:0]    accept;
  logic                    pick_found;
  logic [PW-1:0]           pick_idx;
  logic [PW-1:0]           grant_inc;

  // Per-port datapath: data slicing, start eligibility and credit next-state.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic signed [SUM_W-1:0] bkt_ext;
    logic signed [SUM_W-1:0] rate_ext;
    logic signed [SUM_W-1:0] cost_ext;
    logic signed [SUM_W-1:0] sum;

    assign data_arr[gi] = in_data[gi*DWB +: DWB];
    assign eligible[gi] = cfg_enable[gi] & in_valid[gi] & (bucket_q[gi] >= BEAT_COST);
    assign accept[gi]   = in_valid[gi] & in_ready[gi];

    // Refill and debit land in the same cycle; the result saturates both ways
    // so a long message can leave a carried deficit but never wrap.
    assign bkt_ext  = {{2{bucket_q[gi][BKT_W-1]}}, bucket_q[gi]};
    assign rate_ext = {{(SUM_W-RATE_W){1'b0}}, cfg_rate[gi*RATE_W +: RATE_W]};
    assign cost_ext = accept[gi] ? COST_EXT : '0;
    assign sum      = bkt_ext + rate_ext - cost_ext;
    assign bucket_d[gi] = (sum > SUM_MAX) ? BUCKET_MAX :
                          (sum < SUM_MIN) ? BUCKET_MIN :
                          sum[BKT_W-1:0];
  end

  // Round-robin search: first eligible port at or after the pointer, wrapping.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      if (!pick_found && eligible[PW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  assign grant_inc = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

  // FSM next-state and egress mux: IDLE arbitrates, BUSY forwards the granted port.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    msg_cnt_d = msg_cnt_q;
    in_ready  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        out_valid          = in_valid[grant_q];
        out_last           = in_last[grant_q];
        out_data           = data_arr[grant_q];
        in_ready[grant_q]  = out_ready;
        if (in_valid[grant_q] && out_ready && in_last[grant_q]) begin
          msg_cnt_d = msg_cnt_q + 32'd1;
          rr_d      = grant_inc;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers; reset drops any in-flight message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      msg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      msg_cnt_q <= msg_cnt_d;
    end
  end

  // Credit buckets start full so every port can send immediately after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        bucket_q[i] <= BUCKET_MAX;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        bucket_q[i] <= bucket_d[i];
      end
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign out_port = grant_q;
  assign msg_cnt  = msg_cnt_q;

endmodule

// File: tb/tb_rates_msg_scheduler.sv
// Bench for rates_msg_scheduler: directed scenarios with hand-computed
// expectations plus a randomized run, all compared every cycle against a
// behavioural model of grants, credits and message counting.
module tb_rates_msg_scheduler;

  localparam int NP   = 4;
  localparam int DW   = 16;
  localparam int RW   = 8;
  localparam int BW   = 16;
  localparam int DWB  = DW * 8;
  localparam int BMAX = (1 << (BW - 1)) - 1;
  localparam int BMIN = -(1 << (BW - 1));

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     cfg_enable;
  logic [NP*RW-1:0]  cfg_rate;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_last;
  logic [NP*DWB-1:0] in_data;
  logic [NP-1:0]     in_ready;
  logic              out_valid;
  logic              out_last;
  logic [DWB-1:0]    out_data;
  logic              out_ready;
  logic [1:0]        out_port;
  logic              busy;
  logic [31:0]       msg_cnt;

  always #5 clk = ~clk;

  rates_msg_scheduler #(
    .NUM_PORTS(NP), .DATA_WIDTH_IN_BYTES(DW), .RATE_W(RW), .BKT_W(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_rate(cfg_rate),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
    .out_ready(out_ready), .out_port(out_port), .busy(busy), .msg_cnt(msg_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int          m_busy;
  int          m_g;
  int          m_rr;
  logic [31:0] m_cnt;
  int          m_bkt [NP];

  // Requester sources.
  int             rem [NP];
  logic [DWB-1:0] src_data [NP];
  logic [NP-1:0]  src_on;
  int             vprob, len_min, len_max, rdy_prob;

  logic       last_hs;
  logic [1:0] last_port;

  task automatic chk(input string nm, input logic [DWB-1:0] act, input logic [DWB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DWB-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int clampb(input int v);
    if (v > BMAX) return BMAX;
    if (v < BMIN) return BMIN;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_g    = 0;
    m_rr   = 0;
    m_cnt  = '0;
    for (int i = 0; i < NP; i++) begin
      m_bkt[i] = BMAX;
      rem[i]   = 0;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NP; i++) begin
      if (src_on[i] && rem[i] == 0) rem[i] = $urandom_range(len_min, len_max);
      in_valid[i] = src_on[i] && ($urandom_range(0, 99) < vprob);
      in_last[i]  = (rem[i] == 1);
      in_data[i*DWB +: DWB] = src_data[i];
    end
    out_ready = ($urandom_range(0, 99) < rdy_prob);
  endtask

  // One clock: drive, compare against the model, advance the model, take the edge.
  task automatic step();
    logic [NP-1:0] e_ready;
    logic          e_valid;
    logic [NP-1:0] elig, acc;
    logic          done, found;
    int            j;
    drive_inputs();
    #1;
    e_valid = (m_busy != 0) && in_valid[m_g];
    e_ready = '0;
    if (m_busy != 0) e_ready[m_g] = out_ready;
    chk("busy", busy, m_busy != 0);
    chk("out_port", out_port, m_g);
    chk("msg_cnt", msg_cnt, m_cnt);
    chk("out_valid", out_valid, e_valid);
    chk("in_ready", in_ready, e_ready);
    if (e_valid) begin
      chk("out_last", out_last, in_last[m_g]);
      chk("out_data", out_data, src_data[m_g]);
    end
    last_hs   = out_valid && out_ready;
    last_port = out_port;

    for (int i = 0; i < NP; i++) begin
      elig[i] = cfg_enable[i] && in_valid[i] && (m_bkt[i] >= DW);
      acc[i]  = (m_busy != 0) && (i == m_g) && in_valid[i] && out_ready;
    end
    done = (m_busy != 0) && acc[m_g] && in_last[m_g];
    for (int i = 0; i < NP; i++) begin
      m_bkt[i] = clampb(m_bkt[i] + int'(cfg_rate[i*RW +: RW]) - (acc[i] ? DW : 0));
    end
    if (m_busy != 0) begin
      if (done) begin
        m_cnt  = m_cnt + 32'd1;
        m_rr   = (m_g + 1) % NP;
        m_busy = 0;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < NP; k++) begin
        j = (m_rr + k) % NP;
        if (!found && elig[j]) begin
          found = 1'b1;
          m_g   = j;
        end
      end
      if (found) m_busy = 1;
    end
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        rem[i]      = rem[i] - 1;
        src_data[i] = rnd_word();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_out_port"}, out_port, 0);
    chk({nm, "_msg_cnt"}, msg_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int got[$];
    int exp3[5] = '{0, 1, 2, 3, 0};
    int guard, k, cnt3, others;

    cfg_enable = '0; cfg_rate = '0; in_valid = '0; in_last = '0; in_data = '0;
    out_ready = 1'b0; src_on = '0; vprob = 100; len_min = 1; len_max = 1; rdy_prob = 100;
    for (int i = 0; i < NP; i++) src_data[i] = rnd_word();
    model_reset();
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Single port, 3-beat messages back to back, refill equals cost.
    cfg_enable = '1;
    cfg_rate   = '0;
    cfg_rate[0 +: RW] = 8'd16;
    src_on = 4'b0001; len_min = 3; len_max = 3;
    repeat (8) step();
    chk("t2_msg_cnt", msg_cnt, 2);
    chk("t2_arb_gap_idle", busy, 0);
    repeat (2) step();
    chk("t2_mid_busy", busy, 1);
    do_reset("t1_mid_msg");

    // All ports, single-beat messages: strict rotation.
    for (int i = 0; i < NP; i++) cfg_rate[i*RW +: RW] = 8'd255;
    src_on = 4'b1111; len_min = 1; len_max = 1;
    repeat (12) begin
      step();
      if (last_hs) got.push_back(int'(last_port));
    end
    chk("t3_beats", got.size(), 6);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk("t3_order", got[i], exp3[i]);
    end

    // Port 1 drained into deficit with zero refill, then refilled at 4/cycle.
    do_reset("t4_rst");
    cfg_enable = '1; cfg_rate = '0;
    src_on = 4'b0010; len_min = 2046; len_max = 2046;
    guard = 0;
    while (m_cnt < 1 && guard < 3000) begin step(); guard++; end
    chk("t4_msgA_done", msg_cnt, 1);
    len_min = 2; len_max = 2;
    guard = 0;
    while (m_cnt < 2 && guard < 20) begin step(); guard++; end
    chk("t4_msgB_done", msg_cnt, 2);
    len_min = 1; len_max = 1;
    repeat (20) step();
    chk("t4_starved_idle", busy, 0);
    chk("t4_starved_cnt", msg_cnt, 2);
    cfg_rate[1*RW +: RW] = 8'd4;
    k = 0;
    guard = 0;
    while (guard < 50) begin
      step();
      guard++;
      if (last_hs && last_port == 2'd1) break;
    end
    k = guard;
    chk("t4_refill_cycles", k, 7);

    // Port 3 disabled mid-message: it finishes, then is never granted again.
    do_reset("t6_rst");
    cfg_enable = '1;
    for (int i = 0; i < NP; i++) cfg_rate[i*RW +: RW] = 8'd255;
    src_on = 4'b1000; len_min = 3; len_max = 3;
    guard = 0;
    while (!(m_busy != 0 && m_g == 3) && guard < 10) begin step(); guard++; end
    step();
    chk("t6_first_beat", last_hs, 1);
    cfg_enable[3] = 1'b0;
    src_on = 4'b1111;
    cnt3 = 0; others = 0;
    repeat (40) begin
      step();
      if (last_hs && last_port == 2'd3) cnt3++;
      else if (last_hs) others++;
    end
    chk("t6_port3_beats", cnt3, 2);
    chk("t6_others_served", others >= 8, 1);

    // Drain every bucket close to empty, then random traffic with back-pressure.
    do_reset("drain_rst");
    cfg_enable = '1; cfg_rate = '0;
    src_on = 4'b1111; len_min = 2040; len_max = 2040;
    guard = 0;
    while (m_cnt < 4 && guard < 9000) begin step(); guard++; end
    chk("drain_cnt", msg_cnt, 4);
    for (int i = 0; i < NP; i++) rem[i] = 0;
    len_min = 1; len_max = 6; vprob = 75; rdy_prob = 70;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 64 == 0) begin
        for (int i = 0; i < NP; i++) begin
          cfg_rate[i*RW +: RW] = 8'($urandom_range(0, 24));
          cfg_enable[i]        = ($urandom_range(0, 9) < 8);
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
